// File: rtl/step_sequencer_if.sv
// Control/status bundle for the stepper-motor step sequencer.
// The controller side drives the move request; the sequencer side returns coil drive and progress.
interface step_sequencer_if;
  logic       start;
  logic       abort;
  logic [7:0] count;
  logic [7:0] period;
  logic [3:0] phase;
  logic       busy;
  logic       done;
  logic [7:0] remaining;

  modport master (
    output start, abort, count, period,
    input  phase, busy, done, remaining
  );

  modport slave (
    input  start, abort, count, period,
    output phase, busy, done, remaining
  );
endinterface

// File: rtl/step_sequencer.sv
// Stepper-motor sequencer: issues a signed number of one-hot coil steps,
// one every P clocks, with abort and a one-cycle completion pulse.
module step_sequencer (
  input  logic             clk,
  input  logic             reset,
  step_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [3:0] phase_q, phase_n;
  logic [7:0] rem_q, rem_n;
  logic [7:0] div_q, div_n;
  logic [7:0] p_q, p_n;
  logic       busy_q, done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      phase_q <= 4'b0001;
      rem_q   <= '0;
      div_q   <= '0;
      p_q     <= 8'd1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      phase_q <= phase_n;
      rem_q   <= rem_n;
      div_q   <= div_n;
      p_q     <= p_n;
      busy_q  <= (state_n == S_RUN);
      done_q  <= (state_n == S_DONE);
    end
  end

  always_comb begin
    state_n = state;
    phase_n = phase_q;
    rem_n   = rem_q;
    div_n   = div_q;
    p_n     = p_q;

    case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          rem_n   = bus.count;
          p_n     = (bus.period == 8'd0) ? 8'd1 : bus.period;
          div_n   = '0;
          state_n = (bus.count != 8'd0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        // abort wins over a step falling due on the same edge
        if (bus.abort) begin
          div_n   = '0;
          state_n = S_IDLE;
        end else if (div_q == p_q - 8'd1) begin
          div_n = '0;
          if (rem_q[7]) begin
            phase_n = {phase_q[0], phase_q[3:1]};
            rem_n   = rem_q + 8'd1;
          end else begin
            phase_n = {phase_q[2:0], phase_q[3]};
            rem_n   = rem_q - 8'd1;
          end
          state_n = (rem_n == 8'd0) ? S_DONE : S_RUN;
        end else begin
          div_n = div_q + 8'd1;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: begin
        state_n = S_IDLE;
        div_n   = '0;
      end
    endcase

    // Keep the coil pattern legal even if the register was upset.
    if (!$onehot(phase_n)) phase_n = 4'b0001;
  end

  assign bus.phase     = phase_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.remaining = rem_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: each step pushes the expected post-edge
// outputs to a scoreboard queue, which is popped and checked after every edge.
module tb_step_sequencer;

  logic clk = 1'b0;
  logic reset;

  step_sequencer_if sif ();

  step_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] ph;
    logic       b;
    logic       d;
    logic [7:0] rem;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [3:0] cur_ph;
  logic [7:0] cur_rem;

  function automatic logic [3:0] next_ph(input logic [3:0] p, input bit rev);
    logic [3:0] r;
    case (p)
      4'b0001: r = rev ? 4'b1000 : 4'b0010;
      4'b0010: r = rev ? 4'b0001 : 4'b0100;
      4'b0100: r = rev ? 4'b0010 : 4'b1000;
      default: r = rev ? 4'b0100 : 4'b0001;
    endcase
    return r;
  endfunction

  task automatic push(input string tag, input logic [3:0] ph, input logic b,
                      input logic d, input logic [7:0] rem);
    exp_t e;
    e.tag = tag; e.ph = ph; e.b = b; e.d = d; e.rem = rem;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=no_entry expected=entry");
    end else begin
      e = sb.pop_front();
      assert (sif.phase === e.ph && sif.busy === e.b && sif.done === e.d &&
              sif.remaining === e.rem)
      else begin
        bad++;
        $error("FAIL %s observed ph=%b busy=%b done=%b rem=%h expected ph=%b busy=%b done=%b rem=%h",
               e.tag, sif.phase, sif.busy, sif.done, sif.remaining,
               e.ph, e.b, e.d, e.rem);
      end
    end
  endtask

  // abort_at / reset_at: index of the post-accept RUN edge on which to assert them (0 = never)
  task automatic move(input logic [7:0] c, input logic [7:0] per, input bit hold_start,
                      input int abort_at, input int reset_at, input string tag);
    int pp;
    int r;
    int k;
    pp = (per == 8'd0) ? 1 : int'(per);
    r  = int'($signed(c));
    k  = 0;
    sif.count = c; sif.period = per; sif.start = 1'b1; sif.abort = 1'b0;
    if (r == 0) begin
      push({tag, "_done"}, cur_ph, 1'b0, 1'b1, 8'h00); tick();
      sif.start = 1'b0; cur_rem = 8'h00;
      push({tag, "_idle"}, cur_ph, 1'b0, 1'b0, 8'h00); tick();
      return;
    end
    push({tag, "_accept"}, cur_ph, 1'b1, 1'b0, c); tick();
    if (!hold_start) sif.start = 1'b0;
    sif.count = 8'h55; sif.period = 8'h07;
    while (r != 0) begin
      for (int d = 0; d < pp; d++) begin
        k++;
        if (k == abort_at) begin
          sif.abort = 1'b1;
          cur_rem = r[7:0];
          push({tag, "_abort"}, cur_ph, 1'b0, 1'b0, cur_rem); tick();
          sif.abort = 1'b0; sif.start = 1'b0;
          push({tag, "_abort_idle"}, cur_ph, 1'b0, 1'b0, cur_rem); tick();
          return;
        end
        if (k == reset_at) begin
          reset = 1'b1;
          cur_ph = 4'b0001; cur_rem = 8'h00;
          push({tag, "_reset"}, cur_ph, 1'b0, 1'b0, 8'h00); tick();
          reset = 1'b0; sif.start = 1'b0;
          push({tag, "_post_reset"}, cur_ph, 1'b0, 1'b0, 8'h00); tick();
          return;
        end
        if (d == pp - 1) begin
          cur_ph = next_ph(cur_ph, r < 0);
          r = (r > 0) ? r - 1 : r + 1;
        end
        push({tag, "_run"}, cur_ph, r != 0, r == 0, r[7:0]); tick();
      end
    end
    sif.start = 1'b0; cur_rem = 8'h00;
    push({tag, "_idle"}, cur_ph, 1'b0, 1'b0, 8'h00); tick();
  endtask

  initial begin
    logic [3:0] ph_before;
    reset = 1'b1;
    sif.start = 1'b1; sif.abort = 1'b1; sif.count = 8'h03; sif.period = 8'h02;
    cur_ph = 4'b0001; cur_rem = 8'h00;
    push("reset0", 4'b0001, 1'b0, 1'b0, 8'h00); tick();
    push("reset1", 4'b0001, 1'b0, 1'b0, 8'h00); tick();
    reset = 1'b0; sif.start = 1'b0; sif.abort = 1'b0;
    push("idle0", 4'b0001, 1'b0, 1'b0, 8'h00); tick();

    move(8'd3,   8'd2, 1'b0, 0, 0, "fwd3_p2");
    move(8'hFE,  8'd0, 1'b0, 0, 0, "rev2_p0");
    move(8'd0,   8'd9, 1'b0, 0, 0, "zero");
    move(8'd5,   8'd4, 1'b0, 6, 0, "abort5");

    // abort together with start in IDLE starts nothing
    sif.start = 1'b1; sif.abort = 1'b1; sif.count = 8'd3; sif.period = 8'd1;
    push("start_abort_idle", cur_ph, 1'b0, 1'b0, cur_rem); tick();
    push("start_abort_idle2", cur_ph, 1'b0, 1'b0, cur_rem); tick();
    sif.start = 1'b0; sif.abort = 1'b0;

    move(8'd2,   8'd1, 1'b0, 1, 0, "abort_prio");

    ph_before = cur_ph;
    move(8'h80,  8'd1, 1'b0, 0, 0, "rev128");
    total++;
    assert (sif.phase === ph_before)
    else begin
      bad++;
      $error("FAIL rev128_phase observed=%b expected=%b", sif.phase, ph_before);
    end

    move(8'd10,  8'd2, 1'b1, 5, 0, "hold_start_abort");
    move(8'd10,  8'd2, 1'b1, 0, 5, "reset_mid");
    move(8'hFF,  8'd3, 1'b0, 0, 0, "rev1_p3");
    move(8'd1,   8'd255, 1'b0, 0, 0, "fwd1_p255");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 The block SHALL have exactly these ports:
- clk  input  1  rising-edge clock, sole clock domain
- reset  input  1  synchronous reset, active-high
- start  input  1  move request, sampled only in IDLE
- abort  input  1  cancel move in progress
- count  input  8  signed two's-complement step count (positive = forward, negative = reverse, zero = no move)
- period  input  8  unsigned clock cycles per step (0 treated as 1)
- phase  output  4  one-hot coil drive pattern
- busy  output  1  move in progress
- done  output  1  one-cycle pulse when a move completes normally
- remaining  output  8  signed steps still to issue

REQ-002 Clock and reset SHALL be as in REQ-001: one clock, clk; reset synchronous and active-high.

Function
REQ-003 States SHALL be IDLE, RUN and DONE; outputs are registered.
REQ-004 busy SHALL be 1 exactly when the state is RUN; done SHALL be 1 exactly when the state is DONE.
REQ-005 In IDLE with start=1 and abort=0, the next edge SHALL capture count into remaining and max(period,1) into an internal period register P.
REQ-006 On that edge the state SHALL go to RUN if count≠0, else to DONE with phase unchanged.
REQ-007 start SHALL be ignored in RUN and DONE; count and period SHALL be ignored except on the accepting edge.
REQ-008 In RUN, an 8-bit divider SHALL count 0..P-1 from 0 on entry, so each step occupies exactly P cycles.
REQ-009 On the edge where the divider equals P-1:
- phase SHALL advance one position (forward 0001→0010→0100→1000→0001; reverse the opposite order);
- remaining SHALL move one toward zero (decrement if positive, increment if negative);
- the divider SHALL return to 0.
REQ-010 If the updated remaining is 0, the state SHALL go to DONE, otherwise it SHALL stay in RUN.
REQ-011 Direction SHALL be remaining[7] as captured; count=-128 SHALL produce 128 reverse steps without overflow.
REQ-012 DONE SHALL last exactly one cycle, then the state SHALL go to IDLE.
REQ-013 abort=1 in RUN SHALL force IDLE on the next edge:
- done SHALL not pulse;
- phase SHALL hold its value;
- remaining SHALL hold the unissued step count.
REQ-014 abort SHALL take priority over a step due on the same edge.
REQ-015 abort in IDLE or DONE SHALL have no effect, and abort together with start in IDLE SHALL start nothing.
REQ-016 phase SHALL persist across moves so that consecutive moves continue the coil sequence.
REQ-017 phase SHALL always be one-hot; an unexpected state SHALL recover to IDLE.

Reset
REQ-018 While reset=1, on each edge: state=IDLE, phase=4'b0001, remaining=0, divider=0, P=1, busy=0, done=0.
REQ-019 reset SHALL override start and abort, and reset mid-move SHALL discard the move.

Verification
REQ-020 The bench SHALL cover these scenarios:
- count=3, period=2, start at edge N, phase initially 0001 -> busy from N+1; phase 0010@N+2, 0100@N+4, 1000@N+6; remaining 2,1,0; done=1 during cycle N+7 only; busy=0 from N+7.
- count=-2 (8'hFE), period=0 -> treated as P=1; phase 1000@N+1, 0100@N+2; remaining 8'hFF then 0; done pulses once.
- count=0 -> no phase change; busy stays 0; done=1 during cycle N+1.
- count=5, period=4, abort asserted at cycle N+6 -> phase advanced once only; remaining=4; state IDLE; done never pulses.
- count=-128, period=1 -> exactly 128 reverse steps; final phase equals the initial phase; done pulses once.
- reset asserted mid-move, plus start held high during RUN -> reset values per REQ-018 next edge; start during RUN does not alter remaining.
